// File: rtl/smg_decode_module.sv
// Serial seven-segment pattern receiver: collects 8 bits, decodes the digit code,
// and reports a one-cycle Decode_Valid with held Number_Data/DP_Out/Decode_Err.
module smg_decode_module #(
    parameter int MSB_FIRST = 1
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Serial_In,
    input  logic       Shift_En,
    input  logic       Frame_Clr,
    output logic [3:0] Number_Data,
    output logic       DP_Out,
    output logic       Decode_Valid,
    output logic       Decode_Err,
    output logic       Busy,
    output logic [1:0] State_Dbg
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] DECODE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0] state_q,   state_d;
    logic [2:0] count_q,   count_d;
    logic [7:0] pattern_q, pattern_d;
    logic [3:0] num_q,     num_d;
    logic       dp_q,      dp_d;
    logic       err_q,     err_d;
    logic       valid_q,   valid_d;

    logic [7:0] shifted;
    logic [7:0] pat_masked;
    logic [3:0] dec_num;
    logic       dec_known;

    // First captured bit must end up in bit 7 (MSB first) or bit 0 (LSB first).
    always_comb begin
        if (MSB_FIRST != 0) shifted = {pattern_q[6:0], Serial_In};
        else                shifted = {Serial_In, pattern_q[7:1]};
    end

    // The DP bit is reported separately, so the digit lookup ignores it.
    always_comb begin
        pat_masked = pattern_q | 8'h80;
        dec_known  = 1'b1;
        dec_num    = 4'd15;
        case (pat_masked)
            8'hC0:   dec_num = 4'd0;
            8'hF9:   dec_num = 4'd1;
            8'hA4:   dec_num = 4'd2;
            8'hB0:   dec_num = 4'd3;
            8'h99:   dec_num = 4'd4;
            8'h92:   dec_num = 4'd5;
            8'h82:   dec_num = 4'd6;
            8'hF8:   dec_num = 4'd7;
            8'h80:   dec_num = 4'd8;
            8'h90:   dec_num = 4'd9;
            8'hBF:   dec_num = 4'd10;
            8'hFF:   dec_num = 4'd15;
            default: dec_known = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pattern_d = pattern_q;
        num_d     = num_q;
        dp_d      = dp_q;
        err_d     = err_q;
        valid_d   = 1'b0;
        // An abort only drops the partial frame; the last reported result stays.
        if (Frame_Clr) begin
            state_d   = IDLE;
            count_d   = 3'd0;
            pattern_d = 8'hFF;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Shift_En) begin
                        pattern_d = shifted;
                        count_d   = 3'd1;
                        state_d   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (Shift_En) begin
                        pattern_d = shifted;
                        if (count_q == 3'd7) begin
                            count_d = 3'd0;
                            state_d = DECODE;
                        end else begin
                            count_d = count_q + 3'd1;
                        end
                    end
                end
                DECODE: begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    if (dec_known) begin
                        num_d = dec_num;
                        dp_d  = ~pattern_q[7];
                        err_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    pattern_d = 8'hFF;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            count_q   <= 3'd0;
            pattern_q <= 8'hFF;
            num_q     <= 4'd15;
            dp_q      <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pattern_q <= pattern_d;
            num_q     <= num_d;
            dp_q      <= dp_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
        end
    end

    assign Number_Data  = num_q;
    assign DP_Out       = dp_q;
    assign Decode_Err   = err_q;
    assign Decode_Valid = valid_q;
    assign Busy         = (state_q == DECODE) || (state_q == DONE);
    assign State_Dbg    = state_q;

endmodule

// File: tb/tb_smg_decode_module.sv
// Bench for smg_decode_module (MSB_FIRST=1): frames are driven bit 7 first and
// expected {err, dp, num} results are queued, then popped on each Decode_Valid.
module tb_smg_decode_module;

    logic       clk;
    logic       rst_n;
    logic       serial_in;
    logic       shift_en;
    logic       frame_clr;
    logic [3:0] number_data;
    logic       dp_out;
    logic       decode_valid;
    logic       decode_err;
    logic       busy;
    logic [1:0] state_dbg;

    int checks_cnt = 0;
    int fail_cnt   = 0;
    int valid_cnt  = 0;

    logic [5:0] exp_q[$];
    logic [3:0] model_num = 4'd15;
    logic       model_dp  = 1'b0;

    smg_decode_module #(.MSB_FIRST(1)) dut (
        .CLK          (clk),
        .RSTn         (rst_n),
        .Serial_In    (serial_in),
        .Shift_En     (shift_en),
        .Frame_Clr    (frame_clr),
        .Number_Data  (number_data),
        .DP_Out       (dp_out),
        .Decode_Valid (decode_valid),
        .Decode_Err   (decode_err),
        .Busy         (busy),
        .State_Dbg    (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: every Decode_Valid pulse consumes one expected entry
    always @(negedge clk) begin
        if (decode_valid) begin
            logic [5:0] exp;
            logic [5:0] got;
            valid_cnt++;
            checks_cnt++;
            got = {decode_err, dp_out, number_data};
            if (exp_q.size() == 0) begin
                fail_cnt++;
                $display("FAIL scoreboard_unexpected_valid: got %h, expected no pulse", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    fail_cnt++;
                    $display("FAIL scoreboard_result: got {err,dp,num}=%b, expected %b", got, exp);
                end
            end
        end
    end

    // independent reference table: returns {known, num}
    function automatic logic [4:0] ref_lookup(input logic [7:0] p);
        logic [7:0] m;
        m = p | 8'h80;
        case (m)
            8'hC0: return {1'b1, 4'd0};
            8'hF9: return {1'b1, 4'd1};
            8'hA4: return {1'b1, 4'd2};
            8'hB0: return {1'b1, 4'd3};
            8'h99: return {1'b1, 4'd4};
            8'h92: return {1'b1, 4'd5};
            8'h82: return {1'b1, 4'd6};
            8'hF8: return {1'b1, 4'd7};
            8'h80: return {1'b1, 4'd8};
            8'h90: return {1'b1, 4'd9};
            8'hBF: return {1'b1, 4'd10};
            8'hFF: return {1'b1, 4'd15};
            default: return {1'b0, 4'd0};
        endcase
    endfunction

    task automatic push_expected(input logic [7:0] p);
        logic [4:0] r;
        r = ref_lookup(p);
        if (r[4]) begin
            model_num = r[3:0];
            model_dp  = ~p[7];
            exp_q.push_back({1'b0, model_dp, model_num});
        end else begin
            exp_q.push_back({1'b1, model_dp, model_num});
        end
    endtask

    // driver tasks
    task automatic shift_bit(input logic b);
        @(negedge clk);
        shift_en  = 1'b1;
        serial_in = b;
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            shift_en  = 1'b0;
            serial_in = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic shift_bits(input logic [7:0] p, input int n);
        for (int i = 7; i > 7 - n; i--) shift_bit(p[i]);
    endtask

    // full frame with latency check: 8th bit at edge N, Valid only between N+1 and N+2
    task automatic send_frame(input logic [7:0] p, input string name);
        shift_bits(p, 7);
        push_expected(p);
        shift_bit(p[0]);
        @(negedge clk);
        shift_en = 1'b0;
        checks_cnt++;
        if (decode_valid !== 1'b0 || busy !== 1'b1) begin
            fail_cnt++;
            $display("FAIL %s_decode_cycle: valid=%b busy=%b, expected valid=0 busy=1", name, decode_valid, busy);
        end
        @(negedge clk);
        checks_cnt++;
        if (decode_valid !== 1'b1 || busy !== 1'b1) begin
            fail_cnt++;
            $display("FAIL %s_done_cycle: valid=%b busy=%b, expected valid=1 busy=1", name, decode_valid, busy);
        end
        @(negedge clk);
        checks_cnt++;
        if (decode_valid !== 1'b0 || busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL %s_after_done: valid=%b busy=%b, expected valid=0 busy=0", name, decode_valid, busy);
        end
    endtask

    task automatic check_outputs(input string name, input logic [3:0] num, input logic dp, input logic err);
        checks_cnt++;
        if (number_data !== num || dp_out !== dp || decode_err !== err) begin
            fail_cnt++;
            $display("FAIL %s: num=%0d dp=%b err=%b, expected num=%0d dp=%b err=%b",
                     name, number_data, dp_out, decode_err, num, dp, err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; serial_in = 1'b0; shift_en = 1'b0; frame_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks_cnt++;
        if (number_data !== 4'd15 || dp_out !== 1'b0 || decode_valid !== 1'b0 ||
            decode_err !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0) begin
            fail_cnt++;
            $display("FAIL reset_values: num=%0d dp=%b valid=%b err=%b busy=%b state=%0d, expected 15 0 0 0 0 0",
                     number_data, dp_out, decode_valid, decode_err, busy, state_dbg);
        end
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_basic();
        send_frame(8'h92, "basic_92");
        check_outputs("basic_92_held", 4'd5, 1'b0, 1'b0);
    endtask

    task automatic test_dp_blank();
        send_frame(8'h40, "dp_40");
        check_outputs("dp_40_held", 4'd0, 1'b1, 1'b0);
        send_frame(8'hFF, "blank_ff");
        check_outputs("blank_ff_held", 4'd15, 1'b0, 1'b0);
    endtask

    task automatic test_error();
        send_frame(8'hB0, "err_pre_b0");
        send_frame(8'hA5, "err_a5");
        check_outputs("err_a5_held", 4'd3, 1'b0, 1'b1);
        send_frame(8'hF9, "err_recover_f9");
        check_outputs("err_recover_held", 4'd1, 1'b0, 1'b0);
    endtask

    task automatic test_pause();
        int v0;
        v0 = valid_cnt;
        shift_bits(8'hB0, 4);
        idle_cycles(5);
        checks_cnt++;
        if (state_dbg !== 2'd1) begin
            fail_cnt++;
            $display("FAIL pause_state: state=%0d, expected 1", state_dbg);
        end
        send_frame_tail(8'hB0, 4, "pause_b0");
        idle_cycles(3);
        checks_cnt++;
        if (valid_cnt - v0 !== 1) begin
            fail_cnt++;
            $display("FAIL pause_valid_count: %0d, expected 1", valid_cnt - v0);
        end
        check_outputs("pause_b0_held", 4'd3, 1'b0, 1'b0);
    endtask

    // last n bits of a frame whose leading bits were already shifted
    task automatic send_frame_tail(input logic [7:0] p, input int n, input string name);
        for (int i = n - 1; i > 0; i--) shift_bit(p[i]);
        push_expected(p);
        shift_bit(p[0]);
        idle_cycles(1);
        checks_cnt++;
        if (busy !== 1'b1) begin
            fail_cnt++;
            $display("FAIL %s_busy: busy=%b, expected 1", name, busy);
        end
    endtask

    task automatic test_frame_clr();
        int v0;
        v0 = valid_cnt;
        shift_bits(8'h3C, 5);
        @(negedge clk);
        frame_clr = 1'b1; shift_en = 1'b1; serial_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_clr = 1'b0; shift_en = 1'b0;
        checks_cnt++;
        if (state_dbg !== 2'd0 || busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL clr_idle: state=%0d busy=%b, expected state=0 busy=0", state_dbg, busy);
        end
        check_outputs("clr_outputs_held", 4'd3, 1'b0, 1'b0);
        send_frame(8'h80, "clr_then_80");
        checks_cnt++;
        if (valid_cnt - v0 !== 1) begin
            fail_cnt++;
            $display("FAIL clr_valid_count: %0d, expected 1", valid_cnt - v0);
        end
        check_outputs("clr_80_held", 4'd8, 1'b0, 1'b0);
    endtask

    task automatic test_clr_in_decode();
        int v0;
        v0 = valid_cnt;
        shift_bits(8'hC0, 8);
        @(negedge clk);
        shift_en = 1'b0; frame_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_clr = 1'b0;
        idle_cycles(3);
        checks_cnt++;
        if (valid_cnt - v0 !== 0) begin
            fail_cnt++;
            $display("FAIL clr_decode_valid_count: %0d, expected 0", valid_cnt - v0);
        end
        check_outputs("clr_decode_held", 4'd8, 1'b0, 1'b0);
    endtask

    task automatic test_busy_drop();
        shift_bits(8'h82, 7);
        push_expected(8'h82);
        shift_bit(1'b0);
        shift_bit(1'b1);
        shift_bit(1'b0);
        idle_cycles(1);
        checks_cnt++;
        if (state_dbg !== 2'd0) begin
            fail_cnt++;
            $display("FAIL busy_drop_state: state=%0d, expected 0", state_dbg);
        end
        send_frame(8'h99, "busy_drop_99");
        check_outputs("busy_drop_held", 4'd4, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        shift_bits(8'h55, 6);
        @(negedge clk);
        shift_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks_cnt++;
        if (number_data !== 4'd15 || dp_out !== 1'b0 || decode_valid !== 1'b0 ||
            decode_err !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0) begin
            fail_cnt++;
            $display("FAIL reset_mid_async: num=%0d dp=%b valid=%b err=%b busy=%b state=%0d, expected 15 0 0 0 0 0",
                     number_data, dp_out, decode_valid, decode_err, busy, state_dbg);
        end
        model_num = 4'd15;
        model_dp  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'hC0, "reset_mid_c0");
        check_outputs("reset_mid_c0_held", 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] tbl [8];
        tbl = '{8'hA4, 8'h12, 8'hF8, 8'h3F, 8'h77, 8'h90, 8'hBF, 8'h00};
        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i], "table_frame");
        end
        for (int i = 0; i < 6; i++) begin
            logic [7:0] p;
            p = 8'($urandom_range(0, 255));
            send_frame(p, "random_frame");
            idle_cycles($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dp_blank();
        test_error();
        test_pause();
        test_frame_clr();
        test_clr_in_decode();
        test_busy_drop();
        test_reset_mid();
        test_back_to_back();
        idle_cycles(3);
        checks_cnt++;
        if (exp_q.size() != 0) begin
            fail_cnt++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
